// File: rtl/cache_repl_pkg.sv
// Shared types and helpers for the cache replacement controllers.
// Way vectors are carried at a fixed maximum width so the helpers can be
// shared by controllers with different associativity (N < MAX_WAYS).
package cache_repl_pkg;

    localparam int MAX_WAYS = 16;

    // Bit i = way i, way 0 is the leftmost bit.
    typedef logic [0:MAX_WAYS-1] way_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DECIDE      = 3'd1,
        ST_REFILL_REQ  = 3'd2,
        ST_REFILL_WAIT = 3'd3,
        ST_UPDATE      = 3'd4
    } state_t;

    // Lowest-index set bit as a one-hot vector; an empty vector selects way 0.
    function automatic way_vec_t pri_onehot(input way_vec_t vec);
        way_vec_t res;
        res    = '0;
        res[0] = 1'b1;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res    = '0;
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

    // Tracker vectors are [MAX_WAYS-1:0] with way 0 in the top bit; flip to way order.
    function automatic way_vec_t bit_rev(input logic [MAX_WAYS-1:0] lru);
        way_vec_t res;
        for (int i = 0; i < MAX_WAYS; i++) begin
            res[i] = lru[MAX_WAYS-1-i];
        end
        return res;
    endfunction

endpackage

// File: rtl/cache_replace_ctrl_if.sv
// Request, tracker and refill signals between a replacement controller and
// its neighbours (tag compare, LRU tracker, next memory level).
interface cache_replace_ctrl_if #(
    parameter int N = 4
);
    logic         req_valid;
    logic         req_ready;
    logic [0:N-1] hit;
    logic [0:N-1] valid;
    logic [N-1:0] lru_in;
    logic [0:N-1] use_way;
    logic         enb;
    logic         refill_valid;
    logic         refill_ready;
    logic [0:N-1] refill_way;
    logic         refill_done;
    logic         resp_valid;
    logic         resp_hit;
    logic [0:N-1] resp_way;
    logic         multi_hit;

    // Controller side.
    modport slave (
        input  req_valid, hit, valid, lru_in, refill_ready, refill_done,
        output req_ready, use_way, enb, refill_valid, refill_way,
               resp_valid, resp_hit, resp_way, multi_hit
    );

    // Environment side (tag stage, tracker and next level together).
    modport master (
        output req_valid, hit, valid, lru_in, refill_ready, refill_done,
        input  req_ready, use_way, enb, refill_valid, refill_way,
               resp_valid, resp_hit, resp_way, multi_hit
    );
endinterface

// File: rtl/cache_replace_ctrl_victim_select.sv
// Victim choice for a miss: first invalid way, otherwise the tracker's LRU way.
// A malformed LRU vector resolves to its lowest-index way, an empty one to way 0.
module victim_select
    import cache_repl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [0:N-1] valid,
    input  logic [N-1:0] lru_in,
    output logic [0:N-1] victim
);

    way_vec_t             inv_ext;
    logic [MAX_WAYS-1:0]  lru_ext;
    way_vec_t             pick;
    logic                 unused_pick_bits;

    // Widen both vectors to the helper width and choose invalid-first, then LRU.
    always_comb begin
        // NOTE: every variable gets a default before any conditional use so no latch is inferred.
        inv_ext                   = '0;
        inv_ext[0 +: N]           = ~valid;
        lru_ext                   = '0;
        lru_ext[MAX_WAYS-1 -: N]  = lru_in;
        if (|inv_ext) begin
            pick = pri_onehot(inv_ext);
        end else begin
            pick = pri_onehot(bit_rev(lru_ext));
        end
        victim = pick[0 +: N];
    end

    assign unused_pick_bits = ^pick[N:MAX_WAYS-1];

endmodule

// File: rtl/cache_replace_ctrl.sv
// Per-set replacement controller: captures a tag-compare result, chooses the
// hit way or a victim, runs the refill handshake on a miss and finally
// strobes the LRU tracker with the serviced way while reporting completion.
module cache_replace_ctrl
    import cache_repl_pkg::*;
#(
    parameter int N = 4
) (
    input logic               clk,
    input logic               rstn,
    cache_replace_ctrl_if.slave bus
);

    state_t       state;
    state_t       state_n;
    logic [0:N-1] hit_q;
    logic [0:N-1] valid_q;
    logic [N-1:0] lru_q;
    logic [0:N-1] way_q;
    logic         hit_path_q;

    logic         accept;
    logic         any_hit;
    logic         multi_in;
    way_vec_t     hit_ext;
    way_vec_t     hit_pick;
    logic [0:N-1] hit_way;
    logic [0:N-1] victim;
    logic [0:N-1] sel_way;
    logic [0:N-1] svc_way;
    logic         unused_hit_bits;

    assign bus.req_ready = (state == ST_IDLE) && rstn;
    assign accept        = bus.req_valid && bus.req_ready;
    assign any_hit       = |hit_q;
    assign multi_in      = |(bus.hit & (bus.hit - N'(1)));

    victim_select #(.N(N)) u_victim (
        .valid  (valid_q),
        .lru_in (lru_q),
        .victim (victim)
    );

    // Lowest-index hit way of the captured request.
    always_comb begin
        hit_ext         = '0;
        hit_ext[0 +: N] = hit_q;
        hit_pick        = pri_onehot(hit_ext);
        hit_way         = hit_pick[0 +: N];
    end

    assign unused_hit_bits = ^hit_pick[N:MAX_WAYS-1];

    // Way under service: decided this cycle in DECIDE, remembered afterwards.
    assign sel_way = any_hit ? hit_way : victim;
    assign svc_way = (state == ST_DECIDE) ? sel_way : way_q;

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:        if (accept) state_n = ST_DECIDE;
            ST_DECIDE:      state_n = any_hit ? ST_UPDATE : ST_REFILL_REQ;
            ST_REFILL_REQ:  if (bus.refill_ready) state_n = ST_REFILL_WAIT;
            ST_REFILL_WAIT: if (bus.refill_done) state_n = ST_UPDATE;
            ST_UPDATE:      state_n = ST_IDLE;
            default:        state_n = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Capture the qualified tag-compare result on acceptance.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: captured request bits are reset too, so nothing from an abandoned request survives reset.
        if (!rstn) begin
            hit_q   <= '0;
            valid_q <= '0;
            lru_q   <= '0;
        end else if (accept) begin
            hit_q   <= bus.hit;
            valid_q <= bus.valid;
            lru_q   <= bus.lru_in;
        end
    end

    // Remember the chosen way and whether it came from a hit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            way_q      <= '0;
            hit_path_q <= 1'b0;
        end else if (state == ST_DECIDE) begin
            way_q      <= sel_way;
            hit_path_q <= any_hit;
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.enb          <= 1'b0;
            bus.use_way      <= '0;
            bus.resp_valid   <= 1'b0;
            bus.resp_hit     <= 1'b0;
            bus.resp_way     <= '0;
            bus.refill_valid <= 1'b0;
            bus.refill_way   <= '0;
            bus.multi_hit    <= 1'b0;
        end else begin
            bus.enb          <= (state_n == ST_UPDATE);
            bus.use_way      <= (state_n == ST_UPDATE) ? svc_way : '0;
            bus.resp_valid   <= (state_n == ST_UPDATE);
            bus.resp_way     <= (state_n == ST_UPDATE) ? svc_way : '0;
            bus.resp_hit     <= (state_n == ST_UPDATE) &&
                                ((state == ST_DECIDE) ? any_hit : hit_path_q);
            bus.refill_valid <= (state_n == ST_REFILL_REQ);
            bus.refill_way   <= ((state_n == ST_REFILL_REQ) || (state_n == ST_REFILL_WAIT))
                                ? svc_way : '0;
            bus.multi_hit    <= accept && multi_in;
        end
    end

endmodule

// File: tb/tb_cache_replace_ctrl.sv
// Self-checking bench for cache_replace_ctrl (N = 4): directed scenarios plus
// randomized transactions against a rule-level model of way selection and timing.
module tb_cache_replace_ctrl;

    localparam int N = 4;
    typedef logic [0:N-1] wv_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    cache_replace_ctrl_if #(.N(N)) bus ();

    cache_replace_ctrl #(.N(N)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // What one transaction looked like from outside; offsets are cycles after acceptance.
    typedef struct {
        bit  accepted;
        int  resp_cyc;
        bit  resp_hit;
        wv_t resp_way;
        wv_t use_seen;
        bit  enb_at_resp;
        int  refill_first;
        int  refill_last;
        wv_t refill_way0;
        bit  refill_way_moved;
        int  multi_cyc;
        bit  use_leak;
        int  enb_count;
        bit  ready_after;
    } obs_t;

    obs_t obs;

    function automatic wv_t onehot(input int i);
        wv_t r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    // Reference rule: lowest hit way, else lowest invalid way, else lowest LRU-flagged way, else way 0.
    function automatic int model_idx(input wv_t h, input wv_t v, input logic [N-1:0] l);
        for (int i = 0; i < N; i++) if (h[i]) return i;
        for (int i = 0; i < N; i++) if (!v[i]) return i;
        for (int i = 0; i < N; i++) if (l[N-1-i]) return i;
        return 0;
    endfunction

    // Runs one request from IDLE; refill_ready/refill_done pulse at the given offsets.
    // Called and returns at posedge+1.
    task automatic do_req(input wv_t h, input wv_t v, input logic [N-1:0] l,
                          input int ready_cyc, input int done_cyc, input int spur_cyc);
        int c;
        bit fin;
        bit have_way;
        c        = 0;
        fin      = 0;
        have_way = 0;
        obs = '{default: 0};
        obs.resp_cyc     = -1;
        obs.refill_first = -1;
        obs.refill_last  = -1;
        obs.multi_cyc    = -1;
        while (!fin && c < 60) begin
            bus.req_valid    = (c == 0);
            bus.hit          = (c == 0) ? h : wv_t'($urandom);
            bus.valid        = (c == 0) ? v : wv_t'($urandom);
            bus.lru_in       = (c == 0) ? l : N'($urandom);
            bus.refill_ready = (c == ready_cyc);
            bus.refill_done  = (c == done_cyc) || (c == spur_cyc);
            @(negedge clk);
            if (c == 0) obs.accepted = bus.req_ready;
            if (bus.multi_hit && obs.multi_cyc < 0) obs.multi_cyc = c;
            if (!bus.enb && bus.use_way != '0) obs.use_leak = 1;
            if (bus.enb) obs.enb_count++;
            if (bus.refill_valid) begin
                if (obs.refill_first < 0) obs.refill_first = c;
                obs.refill_last = c;
            end
            if (obs.refill_first >= 0 && c <= done_cyc) begin
                if (!have_way) begin
                    obs.refill_way0 = bus.refill_way;
                    have_way = 1;
                end else if (bus.refill_way !== obs.refill_way0) begin
                    obs.refill_way_moved = 1;
                end
            end
            if (bus.resp_valid) begin
                obs.resp_cyc    = c;
                obs.resp_hit    = bus.resp_hit;
                obs.resp_way    = bus.resp_way;
                obs.use_seen    = bus.use_way;
                obs.enb_at_resp = bus.enb;
                fin = 1;
            end
            @(posedge clk);
            #1;
            c++;
        end
        bus.req_valid    = 1'b0;
        bus.refill_ready = 1'b0;
        bus.refill_done  = 1'b0;
        @(negedge clk);
        obs.ready_after = bus.req_ready;
        if (bus.enb) obs.enb_count++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.req_ready);
        else n_pass++;
        n_checks++;
        if ({bus.enb, bus.refill_valid, bus.resp_valid, bus.resp_hit, bus.multi_hit,
             bus.use_way, bus.refill_way, bus.resp_way} !== '0)
            $display("FAIL reset_outputs: enb=%b rv=%b resp=%b mh=%b use=%b rw=%b",
                     bus.enb, bus.refill_valid, bus.resp_valid, bus.multi_hit, bus.use_way, bus.refill_way);
        else n_pass++;
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", bus.req_ready);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_hit;
        do_req(4'b0010, 4'b1111, N'($urandom), -1, -1, -1);
        n_checks++;
        if (obs.accepted !== 1'b1) $display("FAIL hit_accept: got %b want 1", obs.accepted);
        else n_pass++;
        n_checks++;
        if (obs.resp_cyc != 2) $display("FAIL hit_latency: got %0d want 2", obs.resp_cyc);
        else n_pass++;
        n_checks++;
        if ({obs.resp_hit, obs.enb_at_resp, obs.resp_way, obs.use_seen} !== {2'b11, onehot(2), onehot(2)})
            $display("FAIL hit_resp: hit=%b enb=%b way=%b use=%b want 1 1 0010 0010",
                     obs.resp_hit, obs.enb_at_resp, obs.resp_way, obs.use_seen);
        else n_pass++;
        n_checks++;
        if (obs.refill_first != -1) $display("FAIL hit_no_refill: refill seen at %0d want none", obs.refill_first);
        else n_pass++;
        n_checks++;
        if ({obs.use_leak, obs.enb_count, obs.ready_after} !== {1'b0, 32'd1, 1'b1})
            $display("FAIL hit_strobe: leak=%b enb_cycles=%0d ready_after=%b want 0 1 1",
                     obs.use_leak, obs.enb_count, obs.ready_after);
        else n_pass++;
    endtask

    task automatic test_miss_invalid;
        do_req(4'b0000, 4'b1101, N'($urandom), 4, 7, -1);
        n_checks++;
        if ({obs.refill_first, obs.refill_last} !== {32'd2, 32'd4})
            $display("FAIL miss_inv_refill_window: got %0d..%0d want 2..4", obs.refill_first, obs.refill_last);
        else n_pass++;
        n_checks++;
        if (obs.refill_way0 !== onehot(2) || obs.refill_way_moved)
            $display("FAIL miss_inv_refill_way: got %b moved=%b want 0010 0", obs.refill_way0, obs.refill_way_moved);
        else n_pass++;
        n_checks++;
        if (obs.resp_cyc != 8) $display("FAIL miss_inv_latency: got %0d want 8", obs.resp_cyc);
        else n_pass++;
        n_checks++;
        if ({obs.resp_hit, obs.resp_way, obs.use_seen} !== {1'b0, onehot(2), onehot(2)})
            $display("FAIL miss_inv_resp: hit=%b way=%b use=%b want 0 0010 0010",
                     obs.resp_hit, obs.resp_way, obs.use_seen);
        else n_pass++;
    endtask

    task automatic test_miss_lru;
        do_req(4'b0000, 4'b1111, 4'b0100, 2, 3, -1);
        n_checks++;
        if (obs.refill_way0 !== onehot(1) || obs.refill_way_moved)
            $display("FAIL miss_lru_refill_way: got %b moved=%b want 0100 0", obs.refill_way0, obs.refill_way_moved);
        else n_pass++;
        n_checks++;
        if (obs.resp_cyc != 4) $display("FAIL miss_lru_min_latency: got %0d want 4", obs.resp_cyc);
        else n_pass++;
        n_checks++;
        if ({obs.enb_at_resp, obs.use_seen, obs.resp_hit} !== {1'b1, onehot(1), 1'b0})
            $display("FAIL miss_lru_update: enb=%b use=%b hit=%b want 1 0100 0",
                     obs.enb_at_resp, obs.use_seen, obs.resp_hit);
        else n_pass++;
    endtask

    task automatic test_multi_hit;
        do_req(4'b0110, wv_t'($urandom), N'($urandom), -1, -1, -1);
        n_checks++;
        if (obs.multi_cyc != 1) $display("FAIL multi_hit_pulse: got cycle %0d want 1", obs.multi_cyc);
        else n_pass++;
        n_checks++;
        if ({obs.resp_hit, obs.resp_way} !== {1'b1, onehot(1)})
            $display("FAIL multi_hit_resp: hit=%b way=%b want 1 0100", obs.resp_hit, obs.resp_way);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int n_bad;
        bus.req_valid = 1'b1;
        bus.hit       = 4'b0000;
        bus.valid     = 4'b1111;
        bus.lru_in    = 4'b0001;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 bus.refill_ready = 1'b1;
        @(posedge clk);
        #1 bus.refill_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.refill_valid, bus.refill_way} !== {1'b0, onehot(3)})
            $display("FAIL rst_mid_wait: rv=%b way=%b want 0 0001", bus.refill_valid, bus.refill_way);
        else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (bus.req_ready !== 1'b0) $display("FAIL rst_mid_ready: got %b want 0", bus.req_ready);
        else n_pass++;
        n_checks++;
        if ({bus.enb, bus.refill_valid, bus.resp_valid, bus.resp_hit, bus.multi_hit,
             bus.use_way, bus.refill_way, bus.resp_way} !== '0)
            $display("FAIL rst_mid_outputs: enb=%b rv=%b rw=%b resp=%b",
                     bus.enb, bus.refill_valid, bus.refill_way, bus.resp_valid);
        else n_pass++;
        @(posedge clk);
        #1 rstn = 1'b1;
        n_bad = 0;
        for (int c = 0; c < 6; c++) begin
            bus.refill_done = (c == 1);
            @(negedge clk);
            if (bus.resp_valid || bus.enb || bus.refill_valid) n_bad++;
            @(posedge clk);
            #1;
        end
        bus.refill_done = 1'b0;
        n_checks++;
        if (n_bad != 0 || bus.req_ready !== 1'b1)
            $display("FAIL rst_mid_after: activity cycles=%0d ready=%b want 0 1", n_bad, bus.req_ready);
        else n_pass++;
        do_req(4'b0000, 4'b1011, N'($urandom), 2, 4, -1);
        n_checks++;
        if (obs.resp_cyc != 5 || obs.resp_way !== onehot(1) || obs.resp_hit !== 1'b0)
            $display("FAIL rst_mid_next_req: cyc=%0d way=%b hit=%b want 5 0100 0",
                     obs.resp_cyc, obs.resp_way, obs.resp_hit);
        else n_pass++;
    endtask

    task automatic test_spurious_done;
        bus.refill_done = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 bus.refill_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.refill_valid, bus.resp_valid, bus.enb} !== 4'b1000)
            $display("FAIL spur_idle: ready=%b rv=%b resp=%b enb=%b want 1 0 0 0",
                     bus.req_ready, bus.refill_valid, bus.resp_valid, bus.enb);
        else n_pass++;
        @(posedge clk);
        #1;
        do_req(4'b1001, 4'b1111, N'($urandom), -1, -1, 1);
        n_checks++;
        if (obs.resp_cyc != 2 || obs.resp_way !== onehot(0) || obs.refill_first != -1)
            $display("FAIL spur_decide_hit: cyc=%0d way=%b refill=%0d want 2 1000 -1",
                     obs.resp_cyc, obs.resp_way, obs.refill_first);
        else n_pass++;
        do_req(4'b0000, 4'b1111, 4'b0010, 2, 4, 1);
        n_checks++;
        if (obs.resp_cyc != 5 || obs.resp_way !== onehot(2))
            $display("FAIL spur_decide_miss: cyc=%0d way=%b want 5 0010", obs.resp_cyc, obs.resp_way);
        else n_pass++;
        do_req(4'b0000, 4'b0111, N'($urandom), 3, 5, 3);
        n_checks++;
        if (obs.resp_cyc != 6 || obs.refill_last != 3 || obs.resp_way !== onehot(0))
            $display("FAIL spur_coincident: cyc=%0d last_rv=%0d way=%b want 6 3 1000",
                     obs.resp_cyc, obs.refill_last, obs.resp_way);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int  exp_q[$];
        int  e;
        int  n_acc;
        int  n_resp;
        int  last;
        bit  iv_ok;
        wv_t h;
        n_acc  = 0;
        n_resp = 0;
        last   = -1;
        iv_ok  = 1;
        for (int c = 0; c < 36; c++) begin
            h                = wv_t'($urandom_range(1, (1 << N) - 1));
            bus.req_valid    = (c < 30);
            bus.hit          = h;
            bus.valid        = wv_t'($urandom);
            bus.lru_in       = N'($urandom);
            bus.refill_ready = 1'b0;
            bus.refill_done  = 1'b0;
            @(negedge clk);
            if (bus.resp_valid) begin
                n_resp++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_resp: unexpected response way=%b", bus.resp_way);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.resp_way !== onehot(e) || bus.resp_hit !== 1'b1 || bus.use_way !== onehot(e))
                        $display("FAIL b2b_resp: way=%b use=%b hit=%b want %b %b 1",
                                 bus.resp_way, bus.use_way, bus.resp_hit, onehot(e), onehot(e));
                    else n_pass++;
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                if (last >= 0 && c - last != 3) iv_ok = 0;
                last = c;
                n_acc++;
                exp_q.push_back(model_idx(h, bus.valid, bus.lru_in));
            end
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        n_checks++;
        if (n_acc != 10 || !iv_ok) $display("FAIL b2b_accept_rate: accepts=%0d spacing_ok=%b want 10 1", n_acc, iv_ok);
        else n_pass++;
        n_checks++;
        if (n_resp != 10) $display("FAIL b2b_resp_count: got %0d want 10", n_resp);
        else n_pass++;
    endtask

    task automatic test_random;
        wv_t          h;
        wv_t          v;
        logic [N-1:0] l;
        int           rc;
        int           dc;
        int           sc;
        int           w;
        bit           is_hit;
        for (int k = 0; k < 24; k++) begin
            h      = ($urandom_range(0, 1) == 1) ? wv_t'($urandom) : '0;
            v      = wv_t'($urandom);
            l      = N'($urandom);
            is_hit = (h != '0);
            rc     = is_hit ? -1 : 2 + int'($urandom_range(0, 2));
            dc     = is_hit ? -1 : rc + 1 + int'($urandom_range(0, 2));
            sc     = ($urandom_range(0, 1) == 1) ? 1 : -1;
            w      = model_idx(h, v, l);
            do_req(h, v, l, rc, dc, sc);
            n_checks++;
            if (obs.resp_cyc != (is_hit ? 2 : dc + 1))
                $display("FAIL rand_latency[%0d]: got %0d want %0d", k, obs.resp_cyc, is_hit ? 2 : dc + 1);
            else n_pass++;
            n_checks++;
            if ({obs.resp_hit, obs.resp_way, obs.use_seen} !== {is_hit, onehot(w), onehot(w)})
                $display("FAIL rand_resp[%0d]: hit=%b way=%b use=%b want %b %b (h=%b v=%b l=%b)",
                         k, obs.resp_hit, obs.resp_way, obs.use_seen, is_hit, onehot(w), h, v, l);
            else n_pass++;
            n_checks++;
            if (obs.multi_cyc != (($countones(h) > 1) ? 1 : -1))
                $display("FAIL rand_multi[%0d]: got cycle %0d for h=%b", k, obs.multi_cyc, h);
            else n_pass++;
            n_checks++;
            if (is_hit ? (obs.refill_first != -1)
                       : (obs.refill_first != 2 || obs.refill_last != rc ||
                          obs.refill_way0 !== onehot(w) || obs.refill_way_moved))
                $display("FAIL rand_refill[%0d]: first=%0d last=%0d way=%b moved=%b want way %b",
                         k, obs.refill_first, obs.refill_last, obs.refill_way0, obs.refill_way_moved, onehot(w));
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rstn             = 1'b1;
        bus.req_valid    = 1'b0;
        bus.hit          = '0;
        bus.valid        = '0;
        bus.lru_in       = '0;
        bus.refill_ready = 1'b0;
        bus.refill_done  = 1'b0;
        #2 rstn = 1'b0;
        test_reset();
        test_hit();
        test_miss_invalid();
        test_miss_lru();
        test_multi_hit();
        test_reset_mid();
        test_spurious_done();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_replace_ctrl.md
# cache_replace_ctrl

Per-set replacement controller for the set-associative caches. It sits between the tag-compare stage and the N-way LRU tracker: it consumes the tracker's one-hot least-recently-used vector and tag hit/valid bits, and picks a way (hit way, first invalid way, or LRU victim). It runs the refill handshake toward the next memory level on a miss, then drives the tracker's USE/ENB inputs so the accessed way becomes most-recently-used.

## Interface
Parameters:
- N, 4, number of ways (≥2); must equal N of the attached LRU tracker

Ports:
- CLK  in  1  clock, all state on rising edge
- RSTN  in  1  asynchronous active-low reset
- REQ_VALID  in  1  lookup request; HIT/VALID/LRU_IN are qualified by it
- REQ_READY  out  1  high only in IDLE with RSTN high
- HIT  in  [0:N-1]  tag match per way, bit i = way i
- VALID  in  [0:N-1]  line valid per way, bit i = way i
- LRU_IN  in  [N-1:0]  from tracker; LRU_IN[N-1-i] = way i is LRU
- USE  out  [0:N-1]  one-hot way to tracker, bit i = way i
- ENB  out  1  tracker update strobe, one cycle
- REFILL_VALID  out  1  refill request to next level
- REFILL_READY  in  1  next level accepts refill request
- REFILL_WAY  out  [0:N-1]  one-hot victim, stable from REFILL_VALID until REFILL_DONE
- REFILL_DONE  in  1  one-cycle pulse, line written
- RESP_VALID  out  1  one-cycle completion pulse
- RESP_HIT  out  1  1 = hit, 0 = completed after refill
- RESP_WAY  out  [0:N-1]  one-hot way serviced
- MULTI_HIT  out  1  one-cycle pulse: >1 HIT bit in captured request

## Operation
- States: IDLE, DECIDE, REFILL_REQ, REFILL_WAIT, UPDATE.
- IDLE: on REQ_VALID && REQ_READY, register HIT, VALID and LRU_IN → DECIDE.
- DECIDE:
  - any captured HIT bit → way = lowest-index hit bit; → UPDATE.
  - more than one HIT bit → also pulse MULTI_HIT.
  - no hit → victim = lowest-index way with VALID=0; if all valid, victim = LRU way. Non-one-hot LRU_IN resolves to its lowest-index way; zero resolves to way 0. → REFILL_REQ.
- REFILL_REQ: REFILL_VALID=1, REFILL_WAY=victim; when REFILL_READY sampled high → REFILL_WAIT (REFILL_VALID drops next cycle).
- REFILL_WAIT: REFILL_VALID=0, REFILL_WAY held; on REFILL_DONE → UPDATE.
  - REFILL_DONE in any other state is ignored.
  - REFILL_DONE coincident with the REFILL_READY handshake is also ignored.
- UPDATE: ENB=1, USE=way, RESP_VALID=1, RESP_WAY=way, RESP_HIT = (path was hit), all for exactly one cycle; → IDLE.
- USE is all-zero whenever ENB=0; USE is always one-hot when ENB=1.
- Reset mid-operation: state → IDLE immediately, outstanding refill abandoned (no response), all outputs deasserted.

## Timing
- All outputs registered except REQ_READY (decoded from state, gated by RSTN).
- Reset values: REQ_READY 0 while RSTN low; every other output 0.
- Hit: accept edge T → DECIDE at T+1 → UPDATE (ENB, RESP_VALID) during cycle T+2; REQ_READY high again at T+3.
- Miss: REFILL_VALID high from cycle T+2. If REFILL_READY is high in cycle K, UPDATE occurs in the cycle after the REFILL_DONE pulse.
- Minimum miss: REFILL_READY high at T+2 and REFILL_DONE at T+3 → UPDATE at T+4.
- Back-to-back: a new request is accepted the cycle after UPDATE; throughput one hit per 3 cycles.
- Tracker sees ENB one cycle; its LRU_IN reflects the update from the following cycle, before the next DECIDE.

## Structure
- Package cache_repl_pkg holds:
  - the state encoding (5 states, localparams);
  - a priority one-hot function (lowest set bit of an [0:N-1] vector, zero → way 0);
  - a bit-reverse helper converting LRU_IN [N-1:0] ordering to [0:N-1].
- One combinational sub-module, victim_select: inputs VALID, LRU_IN; output one-hot victim. Reused by the data-cache and instruction-cache controllers.

## Test plan
- N=4, HIT=0010 (way 2), VALID=1111 → RESP_VALID at T+2, RESP_HIT=1, USE=ENB-qualified 0010, no REFILL_VALID.
- HIT=0000, VALID=1101 → REFILL_WAY=0010 (way 2, first invalid), LRU_IN ignored; REFILL_READY at T+4, REFILL_DONE at T+7 → UPDATE at T+8, RESP_HIT=0.
- HIT=0000, VALID=1111, LRU_IN=4'b0100 (way 1) → REFILL_WAY=0100 held from T+2 until REFILL_DONE; USE=0100 with ENB at UPDATE.
- HIT=0110 → MULTI_HIT pulse at T+1, RESP_WAY=0100 (way 1), RESP_HIT=1.
- Miss in REFILL_WAIT, RSTN low for 1 cycle → REQ_READY 0 during reset, all outputs 0, no RESP_VALID. A later REFILL_DONE pulse is ignored, and the next request completes normally.
- Spurious REFILL_DONE in IDLE and in DECIDE → no state change; REQ_VALID held high continuously → requests accepted exactly every 3 cycles on hits.
